// File: rtl/mem_pkg.sv
// Shared definitions for the MEM stage: access-size encodings, FSM states
// and the alignment check used by both the FSM and the lane logic.
package mem_pkg;

   localparam logic [2:0] SEL_W  = 3'b000;
   localparam logic [2:0] SEL_HS = 3'b001;
   localparam logic [2:0] SEL_HU = 3'b010;
   localparam logic [2:0] SEL_BS = 3'b011;
   localparam logic [2:0] SEL_BU = 3'b100;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_BUSY = 2'd1,
      ST_DONE = 2'd2
   } mem_state_e;

   function automatic logic is_half(input logic [2:0] sel);
      return (sel == SEL_HS) || (sel == SEL_HU);
   endfunction

   function automatic logic is_byte(input logic [2:0] sel);
      return (sel == SEL_BS) || (sel == SEL_BU);
   endfunction

   // Codes 101-111 fall through to word, so they need word alignment.
   function automatic logic is_misaligned(input logic [2:0] sel,
                                          input logic [1:0] lo);
      if (is_byte(sel)) return 1'b0;
      if (is_half(sel)) return lo[0];
      return lo != 2'b00;
   endfunction

endpackage

// File: rtl/mem_lane_align.sv
// Combinational lane logic: store byte-enables / lane replication and
// load lane extraction with sign or zero extension.
module mem_lane_align
   import mem_pkg::*;
(
   input  logic [2:0]  st_sel_i,
   input  logic [1:0]  st_lo_i,
   input  logic [31:0] st_data_i,
   output logic [3:0]  st_be_o,
   output logic [31:0] st_data_o,
   input  logic [2:0]  ld_sel_i,
   input  logic [1:0]  ld_lo_i,
   input  logic [31:0] ld_data_i,
   output logic [31:0] ld_data_o
);

   logic [31:0] ld_sh;

   always_comb begin
      st_be_o   = 4'b1111;
      st_data_o = st_data_i;
      unique case (1'b1)
         is_byte(st_sel_i): begin
            st_be_o   = 4'b0001 << st_lo_i;
            st_data_o = {4{st_data_i[7:0]}};
         end
         is_half(st_sel_i): begin
            st_be_o   = 4'b0011 << st_lo_i;
            st_data_o = {2{st_data_i[15:0]}};
         end
         default: ;
      endcase
   end

   // Move the addressed lane down to bit 0 before extending.
   assign ld_sh = ld_data_i >> {ld_lo_i, 3'b000};

   always_comb begin
      ld_data_o = ld_data_i;
      unique case (ld_sel_i)
         SEL_HS:  ld_data_o = {{16{ld_sh[15]}}, ld_sh[15:0]};
         SEL_HU:  ld_data_o = {16'h0, ld_sh[15:0]};
         SEL_BS:  ld_data_o = {{24{ld_sh[7]}}, ld_sh[7:0]};
         SEL_BU:  ld_data_o = {24'h0, ld_sh[7:0]};
         default: ld_data_o = ld_data_i;
      endcase
   end

endmodule

// File: rtl/mem_access_stage.sv
// MEM stage: turns load/store fields into a req/ack data-memory transaction,
// aligns load data, flags misaligned accesses and stalls while outstanding.
module mem_access_stage
   import mem_pkg::*;
#(
   parameter int ADDR_W = 32,
   parameter int DATA_W = 32
) (
   input  logic              clk,
   input  logic              rset,
   input  logic              mem_read,
   input  logic              mem_write,
   input  logic [2:0]        sel,
   input  logic [ADDR_W-1:0] addr,
   input  logic [DATA_W-1:0] wdata,
   output logic              dm_req,
   output logic              dm_we,
   output logic [ADDR_W-1:0] dm_addr,
   output logic [3:0]        dm_be,
   output logic [DATA_W-1:0] dm_wdata,
   input  logic              dm_ack,
   input  logic [DATA_W-1:0] dm_rdata,
   output logic [DATA_W-1:0] value_Data,
   output logic              mem_busy,
   output logic              addr_err_load,
   output logic              addr_err_store
);

   mem_state_e        state_q, state_d;
   logic              req_q, req_d;
   logic              we_q, we_d;
   logic [ADDR_W-1:0] addr_q, addr_d;
   logic [3:0]        be_q, be_d;
   logic [DATA_W-1:0] wdata_q, wdata_d;
   logic [2:0]        sel_q, sel_d;
   logic [1:0]        lo_q, lo_d;
   logic [DATA_W-1:0] value_q, value_d;

   logic              mis;
   logic              access;
   logic [3:0]        be_n;
   logic [DATA_W-1:0] wd_n;
   logic [DATA_W-1:0] ld_n;

   assign mis    = is_misaligned(sel, addr[1:0]);
   assign access = (mem_read | mem_write) & ~mis;

   mem_lane_align u_align (
      .st_sel_i  (sel),
      .st_lo_i   (addr[1:0]),
      .st_data_i (wdata),
      .st_be_o   (be_n),
      .st_data_o (wd_n),
      .ld_sel_i  (sel_q),
      .ld_lo_i   (lo_q),
      .ld_data_i (dm_rdata),
      .ld_data_o (ld_n)
   );

   always_comb begin
      state_d = state_q;
      req_d   = req_q;
      we_d    = we_q;
      addr_d  = addr_q;
      be_d    = be_q;
      wdata_d = wdata_q;
      sel_d   = sel_q;
      lo_d    = lo_q;
      value_d = value_q;
      unique case (state_q)
         ST_IDLE: begin
            req_d = 1'b0;
            if (access) begin
               req_d   = 1'b1;
               we_d    = mem_write;
               addr_d  = {addr[ADDR_W-1:2], 2'b00};
               be_d    = be_n;
               wdata_d = wd_n;
               sel_d   = sel;
               lo_d    = addr[1:0];
               state_d = ST_BUSY;
            end
         end
         ST_BUSY: begin
            if (dm_ack) begin
               req_d   = 1'b0;
               state_d = ST_DONE;
               if (!we_q) value_d = ld_n;
            end
         end
         ST_DONE: state_d = ST_IDLE;
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rset) begin
      if (rset) begin
         state_q <= ST_IDLE;
         req_q   <= 1'b0;
         we_q    <= 1'b0;
         addr_q  <= '0;
         be_q    <= 4'b0000;
         wdata_q <= '0;
         sel_q   <= SEL_W;
         lo_q    <= 2'b00;
         value_q <= '0;
      end else begin
         state_q <= state_d;
         req_q   <= req_d;
         we_q    <= we_d;
         addr_q  <= addr_d;
         be_q    <= be_d;
         wdata_q <= wdata_d;
         sel_q   <= sel_d;
         lo_q    <= lo_d;
         value_q <= value_d;
      end
   end

   assign dm_req     = req_q;
   assign dm_we      = we_q;
   assign dm_addr    = addr_q;
   assign dm_be      = be_q;
   assign dm_wdata   = wdata_q;
   assign value_Data = value_q;

   assign mem_busy       = ((state_q == ST_IDLE) & access) |
                           (state_q == ST_BUSY);
   assign addr_err_load  = mem_read & mis;
   assign addr_err_store = mem_write & mis;

endmodule

// File: tb/tb_mem_access_stage.sv
// Self-checking bench for mem_access_stage: scoreboard of expected load
// results plus directed bus, stall, misalignment and reset scenarios.
module tb_mem_access_stage;

   logic        clk = 1'b0;
   logic        rset;
   logic        mem_read, mem_write;
   logic [2:0]  sel;
   logic [31:0] addr, wdata;
   logic        dm_req, dm_we;
   logic [31:0] dm_addr;
   logic [3:0]  dm_be;
   logic [31:0] dm_wdata;
   logic        dm_ack;
   logic [31:0] dm_rdata;
   logic [31:0] value_Data;
   logic        mem_busy, addr_err_load, addr_err_store;

   int tests = 0;
   int fails = 0;
   int cyc   = 0;
   int req_cyc, done_cyc;
   logic [31:0] exp_val;
   logic [31:0] sb_q[$];

   always #5 clk = ~clk;
   always @(posedge clk) cyc++;

   mem_access_stage #(.ADDR_W(32), .DATA_W(32)) dut (
      .clk(clk), .rset(rset),
      .mem_read(mem_read), .mem_write(mem_write),
      .sel(sel), .addr(addr), .wdata(wdata),
      .dm_req(dm_req), .dm_we(dm_we), .dm_addr(dm_addr),
      .dm_be(dm_be), .dm_wdata(dm_wdata),
      .dm_ack(dm_ack), .dm_rdata(dm_rdata),
      .value_Data(value_Data), .mem_busy(mem_busy),
      .addr_err_load(addr_err_load), .addr_err_store(addr_err_store)
   );

   function automatic logic [31:0] model_load(input logic [2:0] s,
                                              input logic [1:0] lo,
                                              input logic [31:0] rd);
      logic [7:0]  b;
      logic [15:0] h;
      b = rd[8*lo +: 8];
      h = lo[1] ? rd[31:16] : rd[15:0];
      case (s)
         3'b001:  return {{16{h[15]}}, h};
         3'b010:  return {16'h0, h};
         3'b011:  return {{24{b[7]}}, b};
         3'b100:  return {24'h0, b};
         default: return rd;
      endcase
   endfunction

   task automatic do_access(input logic rd, input logic wr,
                            input logic [2:0] s, input logic [31:0] a,
                            input logic [31:0] wd, input logic [31:0] rdat,
                            input int waits);
      logic [31:0] eaddr, ewd, got;
      logic [3:0]  ebe;
      eaddr = {a[31:2], 2'b00};
      if (s == 3'b011 || s == 3'b100) begin
         ebe = 4'b0001 << a[1:0];
         ewd = {wd[7:0], wd[7:0], wd[7:0], wd[7:0]};
      end else if (s == 3'b001 || s == 3'b010) begin
         ebe = 4'b0011 << a[1:0];
         ewd = {wd[15:0], wd[15:0]};
      end else begin
         ebe = 4'b1111;
         ewd = wd;
      end
      if (rd) exp_val = model_load(s, a[1:0], rdat);
      sb_q.push_back(exp_val);

      @(negedge clk);
      mem_read = rd; mem_write = wr; sel = s; addr = a; wdata = wd;
      dm_ack = 1'b0;
      #1;
      tests++;
      if (mem_busy !== 1'b1 || dm_req !== 1'b0) begin
         fails++;
         $display("FAIL issue: busy=%b req=%b want busy=1 req=0",
                  mem_busy, dm_req);
      end

      @(posedge clk); #1;
      req_cyc = cyc;
      tests++;
      if (dm_req !== 1'b1 || dm_we !== wr || dm_addr !== eaddr ||
          mem_busy !== 1'b1 ||
          (wr && (dm_be !== ebe || dm_wdata !== ewd))) begin
         fails++;
         $display("FAIL bus: req=%b we=%b addr=%h be=%b wd=%h busy=%b want 1 %b %h %b %h 1",
                  dm_req, dm_we, dm_addr, dm_be, dm_wdata, mem_busy,
                  wr, eaddr, ebe, ewd);
      end

      for (int w = 0; w < waits; w++) begin
         @(negedge clk);
         dm_rdata = $urandom;
         #1;
         tests++;
         if (dm_req !== 1'b1 || mem_busy !== 1'b1 || dm_addr !== eaddr) begin
            fails++;
            $display("FAIL wait%0d: req=%b busy=%b addr=%h want 1 1 %h",
                     w, dm_req, mem_busy, dm_addr, eaddr);
         end
         @(posedge clk);
      end

      @(negedge clk);
      dm_ack = 1'b1; dm_rdata = rdat;
      @(posedge clk); #1;
      done_cyc = cyc;
      got = sb_q.pop_front();
      tests++;
      if (dm_req !== 1'b0 || mem_busy !== 1'b0 || value_Data !== got) begin
         fails++;
         $display("FAIL done: req=%b busy=%b value=%h want 0 0 %h",
                  dm_req, mem_busy, value_Data, got);
      end

      @(negedge clk);
      dm_ack = 1'b0; mem_read = 1'b0; mem_write = 1'b0;
      dm_rdata = $urandom;
      @(posedge clk); #1;
   endtask

   task automatic test_reset();
      rset = 1'b1; mem_read = 0; mem_write = 0; sel = 3'b000;
      addr = 32'h0; wdata = 32'h0; dm_ack = 0; dm_rdata = 32'h0;
      exp_val = 32'h0;
      #12;
      tests++;
      if ({dm_req, dm_we, dm_addr, dm_be, dm_wdata, value_Data, mem_busy}
          !== '0) begin
         fails++;
         $display("FAIL reset_vals: req=%b we=%b addr=%h be=%b wd=%h val=%h busy=%b want all 0",
                  dm_req, dm_we, dm_addr, dm_be, dm_wdata, value_Data, mem_busy);
      end
      mem_read = 1'b1; addr = 32'h101; #1;
      tests++;
      if (addr_err_load !== 1'b1 || mem_busy !== 1'b0) begin
         fails++;
         $display("FAIL reset_err: err=%b busy=%b want 1 0",
                  addr_err_load, mem_busy);
      end
      addr = 32'h100; #1;
      tests++;
      if (mem_busy !== 1'b1 || dm_req !== 1'b0) begin
         fails++;
         $display("FAIL reset_busy: busy=%b req=%b want 1 0",
                  mem_busy, dm_req);
      end
      mem_read = 1'b0;
      @(negedge clk); rset = 1'b0;
      @(posedge clk); #1;
   endtask

   task automatic test_word_load();
      do_access(1, 0, 3'b000, 32'h100, 32'h0, 32'hDEADBEEF, 0);
   endtask

   task automatic test_byte_loads();
      do_access(1, 0, 3'b011, 32'h103, 32'h0, 32'h80123456, 3);
      tests++;
      if (value_Data !== 32'hFFFFFF80) begin
         fails++;
         $display("FAIL lb: got %h want ffffff80", value_Data);
      end
      do_access(1, 0, 3'b100, 32'h103, 32'h0, 32'h80123456, 3);
      tests++;
      if (value_Data !== 32'h00000080) begin
         fails++;
         $display("FAIL lbu: got %h want 00000080", value_Data);
      end
      do_access(1, 0, 3'b001, 32'h102, 32'h0, 32'h9ABC1234, 1);
      do_access(1, 0, 3'b010, 32'h102, 32'h0, 32'h9ABC1234, 0);
   endtask

   task automatic test_stores();
      do_access(0, 1, 3'b001, 32'h202, 32'h0000ABCD, 32'h11111111, 1);
      do_access(0, 1, 3'b100, 32'h201, 32'h0000005A, 32'h22222222, 0);
      do_access(0, 1, 3'b000, 32'h204, 32'hCAFEF00D, 32'h33333333, 2);
   endtask

   task automatic test_misaligned();
      @(negedge clk);
      mem_read = 1; mem_write = 0; sel = 3'b000; addr = 32'h101;
      for (int i = 0; i < 3; i++) begin
         #1;
         tests++;
         if (addr_err_load !== 1 || addr_err_store !== 0 ||
             mem_busy !== 0 || dm_req !== 0) begin
            fails++;
            $display("FAIL mis_lw%0d: el=%b es=%b busy=%b req=%b want 1 0 0 0",
                     i, addr_err_load, addr_err_store, mem_busy, dm_req);
         end
         @(negedge clk);
      end
      mem_read = 0; mem_write = 1; sel = 3'b001; addr = 32'h203;
      for (int i = 0; i < 3; i++) begin
         #1;
         tests++;
         if (addr_err_store !== 1 || addr_err_load !== 0 ||
             mem_busy !== 0 || dm_req !== 0) begin
            fails++;
            $display("FAIL mis_sh%0d: es=%b el=%b busy=%b req=%b want 1 0 0 0",
                     i, addr_err_store, addr_err_load, mem_busy, dm_req);
         end
         @(negedge clk);
      end
      mem_write = 0;
      @(posedge clk); #1;
   endtask

   task automatic test_reset_mid();
      @(negedge clk);
      mem_read = 1; sel = 3'b000; addr = 32'h300;
      @(posedge clk); #1;
      tests++;
      if (dm_req !== 1'b1) begin
         fails++;
         $display("FAIL rst_mid_req: req=%b want 1", dm_req);
      end
      @(negedge clk);
      rset = 1'b1; #1;
      tests++;
      if (dm_req !== 1'b0 || value_Data !== 32'h0) begin
         fails++;
         $display("FAIL rst_async: req=%b val=%h want 0 0", dm_req, value_Data);
      end
      exp_val = 32'h0;
      @(negedge clk);
      rset = 1'b0; mem_read = 0;
      @(negedge clk);
      dm_ack = 1'b1; dm_rdata = 32'h12345678;
      @(posedge clk); #1;
      tests++;
      if (dm_req !== 0 || mem_busy !== 0 || value_Data !== 32'h0) begin
         fails++;
         $display("FAIL late_ack: req=%b busy=%b val=%h want 0 0 0",
                  dm_req, mem_busy, value_Data);
      end
      @(negedge clk); dm_ack = 1'b0;
      @(posedge clk); #1;
   endtask

   task automatic test_back_to_back();
      int d;
      do_access(0, 1, 3'b000, 32'h400, 32'h01020304, 32'h0, 0);
      d = done_cyc;
      do_access(1, 0, 3'b010, 32'h402, 32'h0, 32'hBEEF0000, 0);
      tests++;
      if (req_cyc !== d + 2) begin
         fails++;
         $display("FAIL b2b: req cycle %0d want %0d", req_cyc, d + 2);
      end
   endtask

   initial begin
      test_reset();
      test_word_load();
      test_byte_loads();
      test_stores();
      test_misaligned();
      test_reset_mid();
      test_back_to_back();
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
